// File: rtl/fifo_seq_pkg.sv
// Shared types and width helpers for the fifo bank sequencer.
//
// Contents:
//   state_e    - sequencer states (IDLE, FILL, DRAIN, DONE)
//   cnt_width  - width of the drain skew counter for a given DIM
//   sel_width  - width of a fifo index for a given DIM
package fifo_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // The skew counter reaches 2*DIM-2, so it needs $clog2(2*DIM) bits.
   function automatic int cnt_width(input int dim);
      return $clog2(2 * dim);
   endfunction

   // Guard against a zero-width index if someone tries DIM=1.
   function automatic int sel_width(input int dim);
      return (dim > 1) ? $clog2(dim) : 1;
   endfunction

endpackage

// File: rtl/fifo_seq_ctrl_skew_window.sv
// skew_window: combinational diagonal window decode.
//
// Given the skew step k, o_mask[i] is set when row i lies inside the
// diagonal window, i.e. k >= i and k - i < DIM. Row 0 is active for
// k = 0..DIM-1 and row DIM-1 for k = DIM-1..2*DIM-2. Kept as its own
// module so the output-side de-skew logic can reuse the same decode.
//
// Ports:
//   i_k     [CW-1:0]   skew step
//   o_mask  [DIM-1:0]  per-row window mask
module skew_window #(
   parameter int DIM = 8,
   parameter int CW  = 4
) (
   input  logic [CW-1:0]  i_k,
   output logic [DIM-1:0] o_mask
);

   always_comb begin
      o_mask = '0;
      for (int i = 0; i < DIM; i++) begin
         // The subtraction is only evaluated once k >= i, so it never wraps.
         if ((i_k >= CW'(i)) && ((i_k - CW'(i)) < CW'(DIM))) begin
            o_mask[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_seq_ctrl.sv
// fifo_seq_ctrl: fill/drain sequencer for a bank of DIM delay-buffer fifos
// (depth DIM, shift-on-enable) feeding a systolic array.
//
// The fifos are filled one at a time from a single valid/ready stream,
// DIM words each. They are then drained together with a one-cycle-per-row
// diagonal skew while constant zero is muxed onto their d inputs.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      begin a fill+drain sequence (sampled in IDLE only)
//   in_valid   fill word present on the shared fifo d bus
//   in_ready   fill word accepted this cycle when in_valid is also high
//   fifo_en    per-fifo shift enable
//   fill_sel   index of the fifo being filled
//   feed_zero  select constant 0 onto fifo d inputs (drain phase)
//   row_valid  per-row valid: fifo q is valid and shifted out this cycle
//   busy       high in FILL and DRAIN
//   done       one-cycle pulse after the last drain cycle
//
// States:
//   state | meaning
//   IDLE  | waiting for start, all outputs low
//   FILL  | accepting DIM*DIM words, DIM per fifo, fifo 0 first
//   DRAIN | 2*DIM-1 skewed drain steps, no stalls
//   DONE  | single-cycle done pulse, then back to IDLE
//
// DIM must be >= 2.
module fifo_seq_ctrl
   import fifo_seq_pkg::*;
#(
   parameter int DIM = 8,
   parameter int CW  = cnt_width(DIM)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [DIM-1:0]            fifo_en,
   output logic [sel_width(DIM)-1:0] fill_sel,
   output logic                      feed_zero,
   output logic [DIM-1:0]            row_valid,
   output logic                      busy,
   output logic                      done
);

   localparam int SW = sel_width(DIM);

   state_e          r_state;
   state_e          w_state_nxt;
   logic [SW-1:0]   r_col_cnt;
   logic [SW-1:0]   r_fill_sel;
   logic [CW-1:0]   r_k;

   logic            w_accept;
   logic            w_col_last;
   logic            w_sel_last;
   logic            w_k_last;
   logic [DIM-1:0]  w_fill_onehot;
   logic [DIM-1:0]  w_window;

   assign w_accept      = (r_state == FILL) && in_valid;
   assign w_col_last    = (r_col_cnt == SW'(DIM - 1));
   assign w_sel_last    = (r_fill_sel == SW'(DIM - 1));
   assign w_k_last      = (r_k == CW'(2 * DIM - 2));
   assign w_fill_onehot = DIM'(1) << r_fill_sel;

   skew_window #(
      .DIM (DIM),
      .CW  (CW)
   ) u_skew_window (
      .i_k    (r_k),
      .o_mask (w_window)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Counters are held at zero outside FILL/DRAIN so every sequence starts
   // clean; the last accept and the last drain step also wrap them to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col_cnt  <= '0;
         r_fill_sel <= '0;
         r_k        <= '0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_accept) begin
                  if (w_col_last) begin
                     r_col_cnt  <= '0;
                     r_fill_sel <= w_sel_last ? '0 : r_fill_sel + 1'b1;
                  end else begin
                     r_col_cnt  <= r_col_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               r_k <= w_k_last ? '0 : r_k + 1'b1;
            end
            default: begin
               r_col_cnt  <= '0;
               r_fill_sel <= '0;
               r_k        <= '0;
            end
         endcase
      end
   end

   // Outputs depend only on registered state/counters, except that fifo_en
   // in FILL follows in_valid so a word is shifted in the cycle it is accepted.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      fifo_en     = '0;
      fill_sel    = '0;
      feed_zero   = 1'b0;
      row_valid   = '0;
      busy        = 1'b0;
      done        = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = FILL;
            end
         end
         FILL: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            fill_sel = r_fill_sel;
            if (w_accept) begin
               fifo_en = w_fill_onehot;
               if (w_col_last && w_sel_last) begin
                  w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            busy      = 1'b1;
            feed_zero = 1'b1;
            row_valid = w_window;
            fifo_en   = w_window;
            if (w_k_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: doc/fifo_seq_ctrl.md
Name: fifo_seq_ctrl

Overview:
- Sequencer for a bank of DIM delay-buffer fifos (each DEPTH=DIM, shift-on-enable, oldest entry always visible on q) that feed a systolic array.
- Fills the fifos one at a time from a single valid/ready input stream, then drains all of them with a one-cycle-per-row diagonal skew.
- Emits the per-fifo shift enables, the input-mux select and the per-row valid strobes that the array consumes.

Parameters:
- DIM, 8, number of fifos and depth of each fifo; must be >= 2.
- CW, $clog2(2*DIM), width of internal counters.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a fill+drain sequence; sampled in IDLE only
- in_valid  input  1  fill word present on the shared fifo d bus
- in_ready  output  1  controller accepts the fill word this cycle
- fifo_en  output  DIM  per-fifo shift enable (drive each fifo's en)
- fill_sel  output  $clog2(DIM)  index of the fifo currently being filled
- feed_zero  output  1  1 = mux constant 0 onto the fifo d inputs (drain phase)
- row_valid  output  DIM  row_valid[i] = fifo i's q is valid this cycle and is shifted out
- busy  output  1  high in FILL and DRAIN
- done  output  1  one-cycle pulse after the last drain cycle

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all counters 0. in_ready, fifo_en, fill_sel, feed_zero, row_valid, busy and done are all 0. The fifos reset themselves.
- States: IDLE, FILL, DRAIN, DONE (enum in package).
- IDLE: all outputs 0. start=1 -> FILL next cycle. in_valid is ignored.
- FILL:
  - in_ready=1, busy=1, feed_zero=0.
  - Handshake: a word is accepted when in_valid&&in_ready. The accepting cycle asserts fifo_en[fill_sel]=1 combinationally; every other fifo_en bit is 0.
  - col_cnt increments per accepted word. At col_cnt==DIM-1 with an accept, col_cnt wraps to 0 and fill_sel increments.
  - An accept with fill_sel==DIM-1 and col_cnt==DIM-1 moves to DRAIN next cycle.
  - in_valid=0 stalls with no state change and fifo_en=0.
  - Word order: the first accepted word for fifo i becomes fifo i's first drained value.
- DRAIN:
  - in_ready=0, feed_zero=1, busy=1. Skew counter k runs 0..2*DIM-2 (2*DIM-1 cycles total).
  - row_valid[i] = fifo_en[i] = (k>=i) && (k-i<DIM). Fifo 0 is active for k=0..DIM-1; fifo DIM-1 for k=DIM-1..2*DIM-2.
  - k==2*DIM-2 -> DONE next cycle. No stalls are possible in DRAIN.
- DONE: done=1 for exactly one cycle, all other outputs 0, then IDLE. A new start is accepted on the cycle after DONE (in IDLE).
- start while busy or in DONE: ignored, with no effect on the sequence.
- Reset mid-FILL or mid-DRAIN: immediate return to IDLE with outputs 0. No done pulse.
- Latency: start -> first in_ready is 1 cycle. Final fill accept -> first row_valid is 1 cycle. Last row_valid -> done is 1 cycle.
- Zero-stall sequence length: 1 + DIM*DIM + (2*DIM-1) + 1 cycles from start to done.
- All outputs are decoded from registered state/counters. No combinational path from start to any output. The only input-to-output paths are in_valid -> fifo_en and in_valid -> row_valid=0.

Decomposition:
- Package fifo_seq_pkg: state enum (IDLE, FILL, DRAIN, DONE) and a localparam function for counter widths.
- One sub-module: skew_window — a combinational decode of k and DIM into the DIM-bit window mask used for row_valid and drain-phase fifo_en. It is reused by the array's output-side de-skew logic.

Test Plan:
- DIM=4, reset asserted mid-sequence -> all outputs 0 immediately (async); in_valid ignored until the next start.
- DIM=4, start, 16 back-to-back words 1..16 with in_valid=1 -> fifo_en one-hot walks 0001 x4, 0010 x4, 0100 x4, 1000 x4; fill_sel 0,1,2,3; DRAIN begins cycle 18; done pulse at cycle 25.
- DIM=4, same fill with in_valid deasserted every other cycle -> fifo_en=0 on idle cycles; word count and ordering unchanged; done delayed by exactly 16 cycles.
- DIM=4, drain with real fifo models -> row_valid sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000; fifo 0 emits 1,2,3,4 and fifo 3 emits 13..16 starting at k=3.
- start pulsed during FILL and again during DONE -> sequence is unaffected; exactly one done; IDLE reached without restart.
- Reset asserted at k=2 of DRAIN -> IDLE immediately; no done; a subsequent start runs a full clean sequence.
